// File: rtl/mono_frame_buffer_pkg.sv
// Shared defaults and reader state encoding for the mono frame buffer.
package mono_frame_buffer_pkg;

  localparam int SAMPLE_W_DFLT  = 24;
  localparam int DATA_W_DFLT    = 32;
  localparam int FRAME_LEN_DFLT = 1024;
  localparam int CNT_W_DFLT     = 16;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_PRIME  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module frame_bank_ram #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Read data holds while re_i is low, which keeps a stalled beat stable upstream.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/mono_frame_buffer.sv
// Ping-pong frame collector: fills one bank with mono samples while the other
// drains as an AXI4-Stream burst; frames arriving while the reader is busy are dropped.
module mono_frame_buffer
  import mono_frame_buffer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_W_DFLT,
  parameter int DATA_WIDTH   = DATA_W_DFLT,
  parameter int FRAME_LEN    = FRAME_LEN_DFLT,
  parameter int CNT_WIDTH    = CNT_W_DFLT
) (
  input  logic                    M_AXIS_ACLK,
  input  logic                    M_AXIS_ARESETN,
  input  logic                    mono_sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] mono_sample,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic                    M_AXIS_TLAST,
  output logic                    frame_overflow,
  output logic [CNT_WIDTH-1:0]    frames_emitted
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]       RD_ONE   = (IDX_W + 1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  rd_state_e state_q, state_d;
  logic                    wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [IDX_W:0]          rd_idx_q, rd_idx_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]    frames_q, frames_d;
  logic                    rd_en;
  logic [SAMPLE_WIDTH-1:0] rd_data;
  logic                    hs, last_hs, full, swap;

  frame_bank_ram #(
    .WIDTH  (SAMPLE_WIDTH),
    .ADDR_W (IDX_W + 1)
  ) u_ram (
    .clk     (M_AXIS_ACLK),
    .we_i    (mono_sample_valid),
    .waddr_i ({wr_bank_q, wr_idx_q}),
    .wdata_i (mono_sample),
    .re_i    (rd_en),
    .raddr_i ({rd_bank_q, rd_idx_q[IDX_W-1:0]}),
    .rdata_o (rd_data)
  );

  assign hs      = tvalid_q && M_AXIS_TREADY;
  assign last_hs = (state_q == RD_STREAM) && hs && tlast_q;
  assign full    = mono_sample_valid && (wr_idx_q == IDX_LAST);
  assign swap    = full && ((state_q == RD_IDLE) || last_hs);

  // rd_idx_q is the next RAM index to fetch; rd_data always holds index rd_idx_q-1,
  // so the beat loaded into the output register is last when rd_idx_q reaches FRAME_LEN.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    ovf_d     = ovf_q;
    frames_d  = frames_q;
    rd_en     = 1'b0;

    if (mono_sample_valid) wr_idx_d = full ? '0 : wr_idx_q + IDX_ONE;
    if (swap) begin
      wr_bank_d = ~wr_bank_q;
      rd_bank_d = wr_bank_q;
    end else if (full) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      RD_IDLE: begin
        if (swap) begin
          state_d  = RD_PRIME;
          rd_idx_d = '0;
        end
      end
      RD_PRIME: begin
        rd_en    = 1'b1;
        rd_idx_d = RD_ONE;
        state_d  = RD_STREAM;
      end
      RD_STREAM: begin
        if (last_hs) begin
          frames_d = frames_q + CNT_ONE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          rd_idx_d = '0;
          state_d  = swap ? RD_PRIME : RD_IDLE;
        end else if (!tvalid_q || hs) begin
          tvalid_d = 1'b1;
          tdata_d  = {{(DATA_WIDTH - SAMPLE_WIDTH){rd_data[SAMPLE_WIDTH-1]}}, rd_data};
          tlast_d  = rd_idx_q[IDX_W];
          rd_en    = !rd_idx_q[IDX_W];
          rd_idx_d = rd_idx_q + RD_ONE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q   <= RD_IDLE;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      ovf_q     <= 1'b0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
      ovf_q     <= ovf_d;
      frames_q  <= frames_d;
    end
  end

  assign M_AXIS_TVALID  = tvalid_q;
  assign M_AXIS_TLAST   = tlast_q;
  assign M_AXIS_TDATA   = tdata_q;
  assign frame_overflow = ovf_q;
  assign frames_emitted = frames_q;

endmodule

// File: tb/tb_mono_frame_buffer.sv
// Scoreboard bench for mono_frame_buffer with a frame-level reference model.
module tb_mono_frame_buffer;

  localparam int SW = 24;
  localparam int DW = 32;
  localparam int FL = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          valid = 1'b0;
  logic          tready = 1'b0;
  logic [SW-1:0] sample = '0;
  logic          tvalid, tlast, ovf;
  logic [DW-1:0] tdata;
  logic [CW-1:0] frames;

  mono_frame_buffer #(
    .SAMPLE_WIDTH (SW),
    .DATA_WIDTH   (DW),
    .FRAME_LEN    (FL),
    .CNT_WIDTH    (CW)
  ) dut (
    .M_AXIS_ACLK       (clk),
    .M_AXIS_ARESETN    (rst_n),
    .mono_sample_valid (valid),
    .mono_sample       (sample),
    .M_AXIS_TVALID     (tvalid),
    .M_AXIS_TREADY     (tready),
    .M_AXIS_TDATA      (tdata),
    .M_AXIS_TLAST      (tlast),
    .frame_overflow    (ovf),
    .frames_emitted    (frames)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t                exp_q[$];
  logic signed [SW-1:0] part[$];
  logic [SW-1:0]        vals[$];
  int                   beats_left = 0;
  int                   frames_exp = 0;
  int                   lat = -1;
  logic                 ovf_exp = 1'b0;
  int                   npass = 0;
  int                   ntot = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
    ntot++;
    if (act == want) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
  endfunction

  // Reference model: a frame is accepted when its last sample arrives while no
  // earlier frame is in flight (or the in-flight frame finishes on that same edge).
  logic signed [DW-1:0] ext_m;
  beat_t                b_m;
  always @(negedge clk) begin
    if (!rst_n) begin
      part.delete();
      exp_q.delete();
      beats_left = 0;
      frames_exp = 0;
      ovf_exp    = 1'b0;
      lat        = -1;
    end else begin
      if (lat >= 0) begin
        lat++;
        if (lat == 2) check("prime_gap", 64'(tvalid), 64'd0);
        else if (lat == 3) begin
          check("tvalid_rise", 64'(tvalid), 64'd1);
          lat = -1;
        end
      end
      if (tvalid && tready && beats_left > 0) begin
        beats_left--;
        if (beats_left == 0) frames_exp++;
      end
      if (valid) begin
        part.push_back(sample);
        if (part.size() == FL) begin
          if (beats_left == 0) begin
            for (int i = 0; i < FL; i++) begin
              ext_m  = part[i];
              b_m.d  = ext_m;
              b_m.l  = (i == FL - 1);
              exp_q.push_back(b_m);
            end
            beats_left = FL;
            lat        = 0;
          end else begin
            ovf_exp = 1'b1;
          end
          part.delete();
        end
      end
    end
  end

  // Monitor: pops one expected beat per handshake and checks stall stability.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic          prev_l = 1'b0;
  beat_t         b_mon;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", 64'({tvalid, tlast, tdata}), 64'({1'b1, prev_l, prev_d}));
      if (tvalid && tready) begin
        check("beat_queued", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          b_mon = exp_q.pop_front();
          check("beat", 64'({tdata, tlast}), 64'({b_mon.d, b_mon.l}));
        end
      end
      stall_prev = tvalid && !tready;
      prev_d     = tdata;
      prev_l     = tlast;
    end
  end

  function automatic logic rdy(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return i[0] == 1'b0;
      2:       return $urandom_range(0, 3) != 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cyc(input logic v, input logic [SW-1:0] s, input logic r);
    @(posedge clk);
    #1;
    valid  = v;
    sample = s;
    tready = r;
  endtask

  task automatic feed(input int mode);
    for (int i = 0; i < vals.size(); i++) cyc(1'b1, vals[i], rdy(mode, i));
    cyc(1'b0, '0, rdy(mode, vals.size()));
  endtask

  task automatic drain(input int mode);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (exp_q.size() == 0 && !tvalid) done = 1'b1;
      else cyc(1'b0, '0, rdy(mode, i));
    end
    check("drain", 64'(done), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    check(tag, 64'({tvalid, tlast, ovf, frames, tdata}), 64'd0);
  endtask

  task automatic chk_status(input string tag, input int fr, input logic ov);
    check({tag, "_frames"}, 64'(frames), 64'(fr));
    check({tag, "_ovf"}, 64'(ovf), 64'(ov));
    check({tag, "_model"}, 64'({ovf, frames}), 64'({ovf_exp, 16'(frames_exp)}));
  endtask

  task automatic rand_vals();
    vals.delete();
    for (int i = 0; i < FL; i++) vals.push_back(SW'($urandom));
  endtask

  task automatic wait_tvalid();
    bit seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      seen = tvalid;
    end
    check("tvalid_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset asserted between edges
    #12 rst_n = 1'b0;
    #1 chk_zero("reset_async");
    repeat (3) begin
      @(negedge clk);
      chk_zero("reset_hold");
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Contiguous frame 1..7,-1 under continuous TREADY
    vals.delete();
    for (int i = 0; i < FL; i++) vals.push_back((i == FL - 1) ? {SW{1'b1}} : SW'(i + 1));
    feed(0);
    wait_tvalid();
    for (int k = 0; k < FL; k++) begin
      check("contig", 64'(tvalid), 64'd1);
      @(negedge clk);
    end
    check("frame_end", 64'(tvalid), 64'd0);
    drain(0);
    chk_status("t2", 1, 1'b0);

    // Same frame, alternating TREADY
    feed(1);
    drain(1);
    chk_status("t3", 2, 1'b0);

    // Overflow while stalled, then a fresh frame
    vals.delete();
    for (int i = 1; i <= 3 * FL; i++) vals.push_back(SW'(i));
    feed(3);
    drain(0);
    chk_status("t4a", 3, 1'b1);
    vals.delete();
    for (int i = 3 * FL + 1; i <= 4 * FL; i++) vals.push_back(SW'(i));
    feed(0);
    drain(0);
    chk_status("t4b", 4, 1'b1);

    // Reset in the middle of a burst
    rand_vals();
    feed(0);
    wait_tvalid();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_mid_frame");
    repeat (3) begin
      @(negedge clk);
      chk_zero("reset_mid_hold");
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    rand_vals();
    feed(0);
    drain(0);
    chk_status("t6", 1, 1'b0);

    // Second frame completes on the edge of the first frame's last handshake
    rand_vals();
    feed(0);
    cyc(1'b0, '0, 1'b1);
    rand_vals();
    feed(0);
    drain(0);
    chk_status("t5", 3, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 2) != 0, SW'($urandom), rdy(2, i));
    cyc(1'b0, '0, 1'b1);
    drain(0);
    check("rand_frames", 64'(frames), 64'(16'(frames_exp)));
    check("rand_ovf", 64'(ovf), 64'(ovf_exp));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
